// File: rtl/game_countdown.sv
// Game-time countdown: loads GAME_SECONDS on entry to GAME, counts down in BCD
// once per CLK_HZ cycles, and flags expiry and the low-time warning.
module game_countdown #(
  parameter int CLK_HZ       = 65_000_000,
  parameter int GAME_SECONDS = 60,
  parameter int LOW_SECONDS  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] state_in,
  output logic       end_of_time,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       sec_tick,
  output logic       time_low
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    GAME  = 2'b10,
    SCORE = 2'b11
  } game_state_t;

  localparam int              PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   PRE_MAX   = PW'(CLK_HZ - 1);
  localparam logic [3:0]      INIT_TENS = 4'(GAME_SECONDS / 10);
  localparam logic [3:0]      INIT_ONES = 4'(GAME_SECONDS % 10);
  localparam int              LOW_CLAMP = (LOW_SECONDS > 99) ? 99 :
                                          ((LOW_SECONDS < 0) ? 0 : LOW_SECONDS);
  localparam logic [6:0]      LOW_BIN   = 7'(LOW_CLAMP);

  game_state_t   state_cur;
  game_state_t   state_d;
  logic [PW-1:0] prescaler, prescaler_n;
  logic [3:0]    tens_n, ones_n;
  logic          eot_n, tick_n, low_n;
  logic [6:0]    secs_bin_n;

  assign state_cur = game_state_t'(state_in);

  // State register: every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_d     <= SCORE;
      prescaler   <= '0;
      sec_tens    <= INIT_TENS;
      sec_ones    <= INIT_ONES;
      end_of_time <= 1'b1;
      sec_tick    <= 1'b0;
      time_low    <= 1'b0;
    end else begin
      state_d     <= state_cur;
      prescaler   <= prescaler_n;
      sec_tens    <= tens_n;
      sec_ones    <= ones_n;
      end_of_time <= eot_n;
      sec_tick    <= tick_n;
      time_low    <= low_n;
    end
  end

  // Next-count logic.
  always_comb begin
    prescaler_n = prescaler;
    tens_n      = sec_tens;
    ones_n      = sec_ones;
    eot_n       = end_of_time;
    tick_n      = 1'b0;
    case (state_cur)
      IDLE, WAIT: begin
        prescaler_n = '0;
        tens_n      = INIT_TENS;
        ones_n      = INIT_ONES;
        eot_n       = 1'b1;
      end
      GAME: begin
        if (state_d != GAME) begin
          prescaler_n = '0;
          tens_n      = INIT_TENS;
          ones_n      = INIT_ONES;
          eot_n       = 1'b1;
        end else if (end_of_time) begin
          if (prescaler == PRE_MAX) begin
            prescaler_n = '0;
            tick_n      = 1'b1;
            if (sec_ones != 4'd0) begin
              ones_n = sec_ones - 4'd1;
            end else if (sec_tens != 4'd0) begin
              ones_n = 4'd9;
              tens_n = sec_tens - 4'd1;
            end
            // The 00:01 -> 00:00 tick also ends the game on the same edge.
            if (sec_tens == 4'd0 && sec_ones == 4'd1) begin
              eot_n = 1'b0;
            end
          end else begin
            prescaler_n = prescaler + 1'b1;
          end
        end
      end
      SCORE: begin
        prescaler_n = prescaler;
      end
    endcase
  end

  // Output decode: warning is evaluated on the digits being loaded this edge.
  always_comb begin
    secs_bin_n = ({3'b000, tens_n} * 7'd10) + {3'b000, ones_n};
    low_n      = (state_cur == GAME) && eot_n && (secs_bin_n <= LOW_BIN);
  end

endmodule

// File: tb/tb_game_countdown.sv
// Self-checking bench for game_countdown: per-cycle scoreboard against a
// cycle-count reference model, plus segment-end vector checks.
module tb_game_countdown;

  localparam int CLK_HZ       = 10;
  localparam int GAME_SECONDS = 12;
  localparam int LOW_SECONDS  = 10;
  localparam int TOTAL        = CLK_HZ * GAME_SECONDS;

  localparam logic [1:0] IDLE_C  = 2'b00;
  localparam logic [1:0] WAIT_C  = 2'b01;
  localparam logic [1:0] GAME_C  = 2'b10;
  localparam logic [1:0] SCORE_C = 2'b11;

  logic       clk;
  logic       rst;
  logic [1:0] state_in;
  logic       end_of_time;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       sec_tick;
  logic       time_low;

  game_countdown #(
    .CLK_HZ      (CLK_HZ),
    .GAME_SECONDS(GAME_SECONDS),
    .LOW_SECONDS (LOW_SECONDS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .state_in   (state_in),
    .end_of_time(end_of_time),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .sec_tick   (sec_tick),
    .time_low   (time_low)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] st;
    int         n;
    logic       eot;
    int         tens;
    int         ones;
    logic       tick;
    logic       low;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [10:0] sb[$];

  // Reference model state
  logic [1:0] m_prev;
  int         m_cnt;
  int         m_rem;
  logic       m_eot;
  logic       m_tick;
  logic       m_low;

  function automatic logic [10:0] pack(input logic eot, input int tens, input int ones,
                                       input logic tick, input logic low);
    return {eot, 4'(tens), 4'(ones), tick, low};
  endfunction

  function automatic logic [10:0] dut_out();
    return {end_of_time, sec_tens, sec_ones, sec_tick, time_low};
  endfunction

  task automatic cmp(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got eot=%0d tens=%0d ones=%0d tick=%0d low=%0d, expected eot=%0d tens=%0d ones=%0d tick=%0d low=%0d",
               name, $time, act[10], act[9:6], act[5:2], act[1], act[0],
               exp[10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic model_reset();
    m_prev = SCORE_C;
    m_cnt  = 0;
    m_rem  = GAME_SECONDS;
    m_eot  = 1'b1;
    m_tick = 1'b0;
    m_low  = 1'b0;
  endtask

  // One clock: drive on the falling edge, predict, check #1 after the rising edge.
  task automatic step(input logic [1:0] st);
    logic [10:0] got;
    @(negedge clk);
    state_in = st;
    m_tick = 1'b0;
    case (st)
      GAME_C: begin
        if (m_prev != GAME_C) begin
          m_cnt = 0;
        end else if (m_cnt < TOTAL) begin
          m_cnt++;
          m_tick = (m_cnt % CLK_HZ) == 0;
        end
        m_rem = GAME_SECONDS - m_cnt / CLK_HZ;
        m_eot = m_cnt < TOTAL;
        m_low = m_eot && (m_rem <= LOW_SECONDS);
      end
      SCORE_C: m_low = 1'b0;
      default: begin
        m_cnt = 0;
        m_rem = GAME_SECONDS;
        m_eot = 1'b1;
        m_low = 1'b0;
      end
    endcase
    m_prev = st;
    sb.push_back(pack(m_eot, m_rem / 10, m_rem % 10, m_tick, m_low));
    @(posedge clk);
    #1;
    got = dut_out();
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty at %0t: got no expected entry, required one", $time);
    end else begin
      cmp("sb_cycle", got, sb.pop_front());
    end
  endtask

  vec_t vecs[21];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{"idle50",         IDLE_C,  50, 1'b1, 1, 2, 1'b0, 1'b0};
    vecs[1]  = '{"load",           GAME_C,   1, 1'b1, 1, 2, 1'b0, 1'b0};
    vecs[2]  = '{"tick1",          GAME_C,  10, 1'b1, 1, 1, 1'b1, 1'b0};
    vecs[3]  = '{"low_rise",       GAME_C,  10, 1'b1, 1, 0, 1'b1, 1'b1};
    vecs[4]  = '{"tick3",          GAME_C,  10, 1'b1, 0, 9, 1'b1, 1'b1};
    vecs[5]  = '{"expire",         GAME_C,  90, 1'b0, 0, 0, 1'b1, 1'b0};
    vecs[6]  = '{"post_expire",    GAME_C,  40, 1'b0, 0, 0, 1'b0, 1'b0};
    vecs[7]  = '{"score_after_exp",SCORE_C,  5, 1'b0, 0, 0, 1'b0, 1'b0};
    vecs[8]  = '{"reload_expired", GAME_C,   1, 1'b1, 1, 2, 1'b0, 1'b0};
    vecs[9]  = '{"mid34",          GAME_C,  34, 1'b1, 0, 9, 1'b0, 1'b1};
    vecs[10] = '{"abort_idle",     IDLE_C,   1, 1'b1, 1, 2, 1'b0, 1'b0};
    vecs[11] = '{"reenter",        GAME_C,   1, 1'b1, 1, 2, 1'b0, 1'b0};
    vecs[12] = '{"reenter_tick",   GAME_C,  10, 1'b1, 1, 1, 1'b1, 1'b0};
    vecs[13] = '{"wait_restore",   WAIT_C,   3, 1'b1, 1, 2, 1'b0, 1'b0};
    vecs[14] = '{"score_load",     GAME_C,   1, 1'b1, 1, 2, 1'b0, 1'b0};
    vecs[15] = '{"pre_score",      GAME_C,  44, 1'b1, 0, 8, 1'b0, 1'b1};
    vecs[16] = '{"score_enter",    SCORE_C,  1, 1'b1, 0, 8, 1'b0, 1'b0};
    vecs[17] = '{"score_hold",     SCORE_C, 20, 1'b1, 0, 8, 1'b0, 1'b0};
    vecs[18] = '{"rst_prep",       IDLE_C,   1, 1'b1, 1, 2, 1'b0, 1'b0};
    vecs[19] = '{"rst_load",       GAME_C,   1, 1'b1, 1, 2, 1'b0, 1'b0};
    vecs[20] = '{"rst_mid",        GAME_C,  56, 1'b1, 0, 7, 1'b0, 1'b1};

    rst      = 1'b1;
    state_in = IDLE_C;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_state", dut_out(), pack(1'b1, 1, 2, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      for (int k = 0; k < vecs[i].n; k++) step(vecs[i].st);
      cmp(vecs[i].name, dut_out(),
          pack(vecs[i].eot, vecs[i].tens, vecs[i].ones, vecs[i].tick, vecs[i].low));
    end

    // Asynchronous reset between edges while mid-count at 0/7.
    #3;
    rst = 1'b1;
    #1;
    cmp("async_rst_immediate", dut_out(), pack(1'b1, 1, 2, 1'b0, 1'b0));
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      cmp("rst_held", dut_out(), pack(1'b1, 1, 2, 1'b0, 1'b0));
    end
    #2;
    rst = 1'b0;

    step(GAME_C);
    cmp("post_rst_load", dut_out(), pack(1'b1, 1, 2, 1'b0, 1'b0));
    repeat (TOTAL - 1) step(GAME_C);
    cmp("post_rst_before_end", dut_out(), pack(1'b1, 0, 1, 1'b0, 1'b1));
    step(GAME_C);
    cmp("post_rst_expire", dut_out(), pack(1'b0, 0, 0, 1'b1, 1'b0));
    repeat (5) step(GAME_C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_countdown.md
GAME_COUNTDOWN -- requirements
Module: game_countdown

Interface
REQ-001 Parameter CLK_HZ, default 65_000_000, pclk cycles per game second; SHALL be >= 2.
REQ-002 Parameter GAME_SECONDS, default 60, game duration in seconds; SHALL be in range 1..99.
REQ-003 Parameter LOW_SECONDS, default 10, threshold for the time_low warning.
REQ-004 clk  input  1  pixel clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 state_in  input  2  game state code: IDLE=2'b00, WAIT=2'b01, GAME=2'b10, SCORE=2'b11.
REQ-007 end_of_time  output  1  high while game time remains; low once time has expired (consumer moves GAME->SCORE on low).
REQ-008 sec_tens  output  4  BCD tens digit of the remaining seconds, for display.
REQ-009 sec_ones  output  4  BCD ones digit of the remaining seconds, for display.
REQ-010 sec_tick  output  1  one-cycle pulse on each decrement of the remaining seconds.
REQ-011 time_low  output  1  high while in GAME with remaining seconds <= LOW_SECONDS and end_of_time=1.

Function
REQ-012 The block SHALL register state_in into state_d every cycle, to detect GAME entry.
REQ-013 Load: when state_in==GAME and state_d!=GAME, the block SHALL set {sec_tens,sec_ones} to GAME_SECONDS in BCD, prescaler to 0, end_of_time to 1 and sec_tick to 0.
REQ-014 Run: on each later edge with state_in==GAME and end_of_time=1, the prescaler SHALL increment.
REQ-015 Wrap: on an edge where the prescaler equals CLK_HZ-1, the prescaler SHALL wrap to 0, sec_tick SHALL be 1 for that cycle only, and the seconds SHALL decrement by 1.
REQ-016 BCD decrement: ones>0 -> ones-1; ones==0 and tens>0 -> ones=9, tens-1; digits SHALL never hold values above 9.
REQ-017 Expiry: on the tick that takes the count from 00:01 to 00:00, end_of_time SHALL go low on the same edge.
REQ-018 After expiry, the prescaler SHALL freeze, the digits SHALL hold 0, no further sec_tick SHALL occur, and end_of_time SHALL stay low until the next load.
REQ-019 The load edge SHALL be followed by the first sec_tick after exactly CLK_HZ cycles, and by end_of_time low after exactly GAME_SECONDS*CLK_HZ cycles.
REQ-020 In IDLE and WAIT, the block SHALL hold the prescaler at 0, the digits at GAME_SECONDS, end_of_time at 1 and sec_tick at 0.
REQ-021 In SCORE, the block SHALL hold the prescaler, digits and end_of_time at their last values, with sec_tick at 0.
REQ-022 Leaving GAME mid-count (for example a stop click returning to IDLE) SHALL abandon the count; IDLE/WAIT rules apply from the next edge.
REQ-023 Re-entering GAME SHALL always reload per REQ-013, even if the previous run had expired.
REQ-024 time_low SHALL be a registered output, updated on the same edge as the digits.
REQ-025 The prescaler SHALL be sized to ceil(log2(CLK_HZ)) bits.
REQ-026 Every output SHALL be driven from a flip-flop; no combinational input-to-output path SHALL exist.

Reset
REQ-027 While rst=1, regardless of clk, the block SHALL hold: state_d=SCORE, prescaler=0, digits=GAME_SECONDS in BCD, end_of_time=1, sec_tick=0, time_low=0.
REQ-028 After rst falls with state_in==GAME, the first edge SHALL perform a load (state_d=SCORE != GAME).
REQ-029 rst asserted mid-count SHALL abort the count at once, with no sec_tick glitch.

Verification (CLK_HZ=10, GAME_SECONDS=12, LOW_SECONDS=10)
REQ-030 Reset then IDLE for 50 cycles -> digits 1/2, end_of_time=1, sec_tick never high.
REQ-031 IDLE->GAME at edge E -> sec_tick at E+10, E+20, ...; digits 1/1 at E+10 and 0/9 at E+30; time_low rises at E+20; end_of_time falls at E+120 with digits 0/0.
REQ-032 Stay in GAME 40 cycles past expiry -> end_of_time=0, digits 0/0, no sec_tick; then GAME->SCORE -> values hold.
REQ-033 GAME entered, then IDLE at E+35 -> digits return to 1/2 next edge; re-enter GAME at F -> first sec_tick at F+10.
REQ-034 Assert rst asynchronously at E+57, between edges -> outputs take reset values before the next edge; release with state_in=GAME -> fresh 120-cycle countdown.
REQ-035 GAME->SCORE at E+45 -> digits frozen at 0/8, end_of_time=1, no sec_tick while in SCORE.
